// File: rtl/atom_reg_loader.sv
// atom_reg_loader: FIFO-buffered feeder for the lock-gated atom register.
// Emits one lock-low cycle per byte with an optional lock-high gap between loads.
module atom_reg_loader #(
  parameter int DEPTH = 4,
  parameter int GAP   = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          pause,
  output logic          full,
  output logic          overflow,
  output logic [CW-1:0] count,
  output logic [7:0]    data_out,
  output logic          lock_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP < 1) ? 1 : $clog2(GAP + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [GW-1:0]   gap_cnt;
  logic [GW-1:0]   gap_nxt;
  logic [CW-1:0]   count_nxt;
  logic            push;
  logic            pop;
  logic            can_pop;

  // full blocks a push even when a pop frees a slot on the same edge
  assign push    = wr_en && !full;
  assign can_pop = (count != '0) && !pause;

  // state register and gap counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  // next state, pop decision and gap countdown
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (can_pop) begin
          pop       = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (GAP == 0) begin
          if (can_pop) begin
            pop       = 1'b1;
            state_nxt = LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          gap_nxt   = GW'(GAP);
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        gap_nxt = gap_cnt - GW'(1);
        if (gap_cnt == GW'(1)) begin
          if (can_pop) begin
            pop       = 1'b1;
            state_nxt = LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // occupancy after this edge's push/pop
  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // byte storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // pointers, flags and registered downstream outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
      data_out <= 8'h00;
      lock_out <= 1'b1;
    end else begin
      overflow <= wr_en && full;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + AW'(1);
      end
      count    <= count_nxt;
      full     <= (count_nxt == CW'(DEPTH));
      lock_out <= (state_nxt != LOAD);
    end
  end

endmodule

// File: tb/tb_atom_reg_loader.sv
// tb_atom_reg_loader: directed bench driving a GAP=2 and a GAP=0 loader
// from the same stimulus, checking lock/data timing and byte order.
module tb_atom_reg_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       pause;

  logic       full_a, ovf_a, lock_a;
  logic [2:0] count_a;
  logic [7:0] data_a;
  logic       full_b, ovf_b, lock_b;
  logic [2:0] count_b;
  logic [7:0] data_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] cap_a [$];
  logic [7:0] cap_b [$];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  atom_reg_loader #(.DEPTH(4), .GAP(2)) u_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .pause(pause), .full(full_a), .overflow(ovf_a), .count(count_a),
    .data_out(data_a), .lock_out(lock_a)
  );

  atom_reg_loader #(.DEPTH(4), .GAP(0)) u_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .pause(pause), .full(full_b), .overflow(ovf_b), .count(count_b),
    .data_out(data_b), .lock_out(lock_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock edge; outputs sampled 1ns later, captures recorded
  task automatic tick();
    @(posedge clk);
    #1;
    if (lock_a === 1'b0) cap_a.push_back(data_a);
    if (lock_b === 1'b0) cap_b.push_back(data_b);
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic chk_caps(input string tag);
    chk({tag, "_na"}, cap_a.size(), exp_q.size());
    chk({tag, "_nb"}, cap_b.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < cap_a.size()) chk({tag, "_a"}, cap_a[i], exp_q[i]);
      if (i < cap_b.size()) chk({tag, "_b"}, cap_b[i], exp_q[i]);
    end
  endtask

  initial begin
    logic       exp_l [10];
    logic [7:0] exp_d [10];
    int         sent;
    int         cyc;

    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    pause   = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_lock", lock_a, 1'b1);
    chk("rst_data", data_a, 8'h00);
    chk("rst_full", full_a, 1'b0);
    chk("rst_ovf", ovf_a, 1'b0);
    chk("rst_count", count_a, 3'd0);
    chk("rst_lock_b", lock_b, 1'b1);

    // latency: push at edge 1, load visible after edge 2
    push_byte(8'hA5);
    chk("lat_e1_lock", lock_a, 1'b1);
    chk("lat_e1_count", count_a, 3'd1);
    tick();
    chk("lat_e2_lock", lock_a, 1'b0);
    chk("lat_e2_data", data_a, 8'hA5);
    chk("lat_e2_count", count_a, 3'd0);
    chk("lat_e2_lock_b", lock_b, 1'b0);
    tick();
    chk("lat_e3_lock", lock_a, 1'b1);
    chk("lat_e3_data", data_a, 8'hA5);
    tick();
    tick();
    tick();

    // GAP=2 spacing: 11,22,33 pushed back to back
    exp_l = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_d = '{8'hA5, 8'h11, 8'h11, 8'h11, 8'h22,
              8'h22, 8'h22, 8'h33, 8'h33, 8'h33};
    for (int i = 0; i < 10; i++) begin
      if (i < 3) begin
        wr_en   = 1'b1;
        wr_data = 8'h11 * 8'(i + 1);
      end else begin
        wr_en = 1'b0;
      end
      tick();
      chk("gap_lock", lock_a, exp_l[i]);
      chk("gap_data", data_a, exp_d[i]);
    end
    wr_en = 1'b0;
    tick();
    chk("gap_end_count", count_a, 3'd0);
    tick();

    // fill under pause, overflow, then GAP=0 burst
    cap_a.delete();
    cap_b.delete();
    pause = 1'b1;
    for (int i = 1; i <= 4; i++) push_byte(8'(i));
    chk("fill_count_b", count_b, 3'd4);
    chk("fill_full_b", full_b, 1'b1);
    chk("fill_full_a", full_a, 1'b1);
    chk("fill_ovf_pre", ovf_b, 1'b0);
    push_byte(8'hFF);
    chk("ovf_b", ovf_b, 1'b1);
    chk("ovf_a", ovf_a, 1'b1);
    chk("ovf_count_b", count_b, 3'd4);
    pause = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("burst_lock_b", lock_b, 1'b0);
      chk("burst_data_b", data_b, 8'(i));
      if (i == 1) begin
        chk("ovf_clear", ovf_b, 1'b0);
        chk("burst_full_b", full_b, 1'b0);
      end
    end
    tick();
    chk("burst_idle_lock", lock_b, 1'b1);
    chk("burst_idle_data", data_b, 8'h04);
    chk("burst_idle_count", count_b, 3'd0);
    for (int i = 0; i < 12; i++) tick();
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    chk_caps("fill_order");

    // wrap-around: 14 bytes through a 4-deep FIFO
    cap_a.delete();
    cap_b.delete();
    exp_q.delete();
    sent = 0;
    cyc  = 0;
    while (sent < 14 && cyc < 300) begin
      if (!full_a) begin
        wr_en   = 1'b1;
        wr_data = 8'h40 + 8'(sent);
        exp_q.push_back(wr_data);
        sent++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      cyc++;
    end
    wr_en = 1'b0;
    chk("wrap_sent", sent, 14);
    for (int i = 0; i < 20; i++) tick();
    chk_caps("wrap_order");
    chk("wrap_count_a", count_a, 3'd0);

    // pause holds off loads; release starts one at next edge
    cap_a.delete();
    cap_b.delete();
    pause = 1'b1;
    push_byte(8'h71);
    push_byte(8'h72);
    tick();
    tick();
    tick();
    chk("pause_ncap_a", cap_a.size(), 0);
    chk("pause_ncap_b", cap_b.size(), 0);
    chk("pause_count_a", count_a, 3'd2);
    chk("pause_count_b", count_b, 3'd2);
    pause = 1'b0;
    tick();
    chk("unpause_lock_a", lock_a, 1'b0);
    chk("unpause_data_a", data_a, 8'h71);
    chk("unpause_lock_b", lock_b, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    exp_q = '{8'h71, 8'h72};
    chk_caps("pause_order");

    // reset during LOAD with 3 bytes still queued
    pause = 1'b1;
    for (int i = 0; i < 4; i++) push_byte(8'h81 + 8'(i));
    pause = 1'b0;
    tick();
    chk("mid_lock_a", lock_a, 1'b0);
    chk("mid_count_a", count_a, 3'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_lock_a", lock_a, 1'b1);
    chk("mid_rst_data_a", data_a, 8'h00);
    chk("mid_rst_count_a", count_a, 3'd0);
    chk("mid_rst_full_a", full_a, 1'b0);
    chk("mid_rst_lock_b", lock_b, 1'b1);
    chk("mid_rst_count_b", count_b, 3'd0);
    cap_a.delete();
    cap_b.delete();
    for (int i = 0; i < 10; i++) tick();
    chk("post_rst_ncap_a", cap_a.size(), 0);
    chk("post_rst_ncap_b", cap_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
